// File: rtl/ram_string_sender.sv
// Walks the message RAM from address 0 and streams each character to the UART until a NUL or the last location.
// Latency: 2 cycles per character minimum; tx_valid/tx_data hold stable and the walk stalls while tx_ready is low.
`timescale 1ns/1ps
module ram_string_sender #(
  parameter int DataWidth  = 7,
  parameter int AddrWidth  = 6,
  parameter int MemorySize = 43,
  parameter int TxWidth    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DataWidth-1:0] ram_dout,
  output logic [AddrWidth-1:0] ram_address,
  output logic                 ram_writeOrread,
  output logic [TxWidth-1:0]   tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int PadWidth = TxWidth - DataWidth;
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(MemorySize - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [AddrWidth-1:0] addr_d;
  logic [DataWidth-1:0] char_q, char_d;
  logic [TxWidth-1:0]   tx_data_d;
  logic                 tx_valid_d;
  logic                 busy_d;
  logic                 done_d;
  logic                 handshake;

  assign ram_writeOrread = 1'b0;
  assign handshake       = tx_valid && tx_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ram_address <= '0;
      char_q      <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_address <= addr_d;
      char_q      <= char_d;
      tx_data     <= tx_data_d;
      tx_valid    <= tx_valid_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = ram_address;
    char_d     = char_q;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
    busy_d     = busy;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d     = 1'b0;
        tx_valid_d = 1'b0;
        if (start) begin
          state_d = FETCH;
          addr_d  = '0;
          busy_d  = 1'b1;
        end
      end

      FETCH: begin
        char_d = ram_dout;
        if (ram_dout == '0) begin
          // A NUL terminates the message and is never offered to the UART.
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          tx_data_d  = {{PadWidth{1'b0}}, ram_dout};
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end

      SEND: begin
        tx_valid_d = 1'b1;
        tx_data_d  = {{PadWidth{1'b0}}, char_q};
        if (handshake) begin
          tx_valid_d = 1'b0;
          // The last location ends the message rather than wrapping to address 0.
          if (ram_address == LastAddr) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            addr_d  = ram_address + AddrWidth'(1);
            state_d = FETCH;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_string_sender.sv
// Scoreboard bench for ram_string_sender: stimulus pushes expected (address, byte) pairs and done counts,
// a negedge monitor pops and compares on every UART handshake and every done pulse.
`timescale 1ns/1ps
module tb_ram_string_sender;

  logic       clock;
  logic       reset;
  logic       start;
  logic [6:0] ram_dout;
  logic [5:0] ram_address;
  logic       ram_writeOrread;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;

  logic [6:0]  mem [43];
  logic [13:0] exp_q [$];
  int          exp_done [$];
  int          sent_cnt;
  int          checks;
  int          passes;

  ram_string_sender dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .ram_dout        (ram_dout),
    .ram_address     (ram_address),
    .ram_writeOrread (ram_writeOrread),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .done            (done)
  );

  assign ram_dout = (ram_address < 6'd43) ? mem[ram_address] : 7'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Monitor: consumes expectations whenever the DUT presents a handshake or a done pulse.
  always @(negedge clock or negedge reset) begin
    if (!reset) begin
      sent_cnt = 0;
    end else begin
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tx", int'(tx_data), -1);
        end else begin
          logic [13:0] e;
          e = exp_q.pop_front();
          check("tx_data", int'(tx_data), int'(e[7:0]));
          check("tx_addr", int'(ram_address), int'(e[13:8]));
          check("writeOrread", int'(ram_writeOrread), 0);
        end
        sent_cnt++;
      end
      if (done) begin
        if (exp_done.size() == 0) check("unexpected_done", sent_cnt, -1);
        else check("done_count", sent_cnt, exp_done.pop_front());
        check("busy_at_done", int'(busy), 1);
        sent_cnt = 0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic load_hi();
    for (int i = 0; i < 43; i++) mem[i] = 7'd0;
    mem[0] = 7'h48;
    mem[1] = 7'h49;
  endtask

  task automatic expect_hi();
    exp_q.push_back({6'd0, 8'h48});
    exp_q.push_back({6'd1, 8'h49});
    exp_done.push_back(2);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      cycles++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", int'(seen), 1);
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("valid_seen", int'(seen), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    checks   = 0;
    passes   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b0;
    load_hi();

    // Reset state, before any clock edge.
    #1;
    check("rst_valid", int'(tx_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(ram_address), 0);
    check("rst_data", int'(tx_data), 0);
    check("rst_wr", int'(ram_writeOrread), 0);
    @(posedge clock); @(posedge clock); #1 reset = 1'b1;

    // T1: "HI" with ready held high.
    tx_ready = 1'b1;
    expect_hi();
    pulse_start();
    @(negedge clock);
    check("t1_busy_e1", int'(busy), 1);
    check("t1_valid_e1", int'(tx_valid), 0);
    @(negedge clock);
    check("t1_valid_e2", int'(tx_valid), 1);
    check("t1_data_e2", int'(tx_data), 8'h48);
    wait_done(20, cyc);
    check("t1_done_latency", cyc, 4);
    @(negedge clock);
    check("t1_busy_after", int'(busy), 0);
    check("t1_done_after", int'(done), 0);

    // T2: backpressure on the first character.
    tx_ready = 1'b0;
    expect_hi();
    pulse_start();
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t2_hold_valid", int'(tx_valid), 1);
      check("t2_hold_data", int'(tx_data), 8'h48);
      check("t2_hold_addr", int'(ram_address), 0);
    end
    @(posedge clock); #1 tx_ready = 1'b1;
    wait_done(20, cyc);
    @(negedge clock);
    check("t2_busy_after", int'(busy), 0);

    // T3: NUL at address 0.
    mem[0] = 7'd0;
    exp_done.push_back(0);
    pulse_start();
    @(negedge clock);
    check("t3_busy_e1", int'(busy), 1);
    check("t3_done_e1", int'(done), 0);
    @(negedge clock);
    check("t3_done_e2", int'(done), 1);
    check("t3_valid_e2", int'(tx_valid), 0);
    @(negedge clock);
    check("t3_busy_e3", int'(busy), 0);
    check("t3_done_e3", int'(done), 0);
    check("t3_valid_e3", int'(tx_valid), 0);

    // T4: every location nonzero, message ends at the last address.
    for (int i = 0; i < 43; i++) begin
      mem[i] = 7'(8'h41 + (i % 26));
      exp_q.push_back({6'(i), 8'(8'h41 + (i % 26))});
    end
    exp_done.push_back(43);
    pulse_start();
    wait_done(200, cyc);
    check("t4_addr_at_done", int'(ram_address), 42);
    @(negedge clock);
    check("t4_busy_after", int'(busy), 0);

    // T5: asynchronous reset in the middle of SEND.
    load_hi();
    tx_ready = 1'b0;
    pulse_start();
    wait_valid(10);
    #2 reset = 1'b0;
    #1;
    check("t5_valid", int'(tx_valid), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_addr", int'(ram_address), 0);
    check("t5_data", int'(tx_data), 0);
    exp_q.delete();
    exp_done.delete();
    @(posedge clock); #1 reset = 1'b1;
    tx_ready = 1'b1;
    expect_hi();
    pulse_start();
    wait_done(20, cyc);
    @(negedge clock);

    // T6: start while busy is ignored; start held high repeats the message.
    expect_hi();
    pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_done(20, cyc);
    repeat (4) @(negedge clock);
    check("t6_no_queue_busy", int'(busy), 0);
    check("t6_no_queue_valid", int'(tx_valid), 0);
    expect_hi();
    expect_hi();
    expect_hi();
    @(posedge clock); #1 start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_done(30, cyc);
      if (r == 2) begin
        start = 1'b0;
      end else begin
        @(negedge clock);
        check("t6_idle_gap", int'(busy), 0);
        @(negedge clock);
        check("t6_restart", int'(busy), 1);
      end
    end
    repeat (4) @(negedge clock);
    check("t6_final_busy", int'(busy), 0);
    check("t6_wr", int'(ram_writeOrread), 0);

    check("exp_q_empty", exp_q.size(), 0);
    check("exp_done_empty", exp_done.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
